// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator that reads the framebuffer once per visible pixel,
// maps the pixel through a writable RGB444 palette and drives pins with aligned sync.
module vga_scanout #(
  parameter int CLOCKS_PER_PIXEL = 4,
  parameter int BITS_PER_PIXEL = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  output logic [31:0]               o_Read_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Read_Data,
  input  logic                      i_Palette_Write_Enable,
  input  logic [BITS_PER_PIXEL-1:0] i_Palette_Index,
  input  logic [11:0]               i_Palette_Data,
  output logic [3:0]                o_Red,
  output logic [3:0]                o_Green,
  output logic [3:0]                o_Blue,
  output logic                      o_HSync,
  output logic                      o_VSync,
  output logic                      o_Frame_Start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLOCKS_PER_PIXEL);
  localparam int PAL_N = 2 ** BITS_PER_PIXEL;
  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [31:0] addr_cnt, addr_now;
  logic tick, origin, h_end, v_end, active, hs_n, vs_n;
  logic s1_active, s1_hs, s1_vs;
  logic [11:0] pal [PAL_N];
  always_comb begin
    tick = div == DW'(CLOCKS_PER_PIXEL - 1);
    origin = h == '0 && v == '0;
    h_end = int'(h) == H_TOTAL - 1;
    v_end = int'(v) == V_TOTAL - 1;
    active = int'(h) < H_VISIBLE && int'(v) < V_VISIBLE;
    hs_n = !(int'(h) >= H_VISIBLE + H_FRONT && int'(h) < H_VISIBLE + H_FRONT + H_SYNC);
    vs_n = !(int'(v) >= V_VISIBLE + V_FRONT && int'(v) < V_VISIBLE + V_FRONT + V_SYNC);
    // clearing at the frame origin makes the address equal V*H_VISIBLE+H without a multiplier
    addr_now = origin ? '0 : addr_cnt;
  end
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      div <= '0;
      h <= '0;
      v <= '0;
      addr_cnt <= '0;
      o_Read_Addr <= '0;
      o_Frame_Start <= 1'b0;
      s1_active <= 1'b0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      {o_Red, o_Green, o_Blue} <= '0;
      o_HSync <= 1'b1;
      o_VSync <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      o_Frame_Start <= tick && origin;
      if (tick) begin
        h <= h_end ? '0 : h + 1'b1;
        if (h_end) v <= v_end ? '0 : v + 1'b1;
        if (active) begin
          o_Read_Addr <= addr_now;
          addr_cnt <= addr_now + 32'd1;
        end
        s1_active <= active;
        s1_hs <= hs_n;
        s1_vs <= vs_n;
        {o_Red, o_Green, o_Blue} <= s1_active ? pal[i_Read_Data] : '0;
        o_HSync <= s1_hs;
        o_VSync <= s1_vs;
      end
    end
  // a write landing on a capture edge is seen from the following capture on
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      for (int n = 0; n < PAL_N; n++) pal[n] <= {3{4'(n)}};
    end else if (i_Palette_Write_Enable) begin
      pal[i_Palette_Index] <= i_Palette_Data;
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the pixel framebuffer: generates 640x480@60 VGA timing and issues one read address per visible pixel.
- Captures the returned pixel index and maps it through a writable 16-entry RGB444 palette.
- Drives the sync and colour pins, with sync and blanking delayed to match the read latency.
- Runs on the system clock; the pixel rate is derived by a clock-enable divider.

Parameters:
- CLOCKS_PER_PIXEL, 4, system clocks per pixel; must be >= 2.
- BITS_PER_PIXEL, 4, framebuffer pixel width; palette depth is 2**BITS_PER_PIXEL.
- H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48, horizontal timing in pixels.
- V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, vertical timing in lines.

Ports:
- i_Clock  input  1  system clock.
- i_Reset  input  1  asynchronous, active-high reset.
- o_Read_Addr  output  32  framebuffer read address.
- i_Read_Data  input  BITS_PER_PIXEL  framebuffer read data; valid one clock after o_Read_Addr changes.
- i_Palette_Write_Enable  input  1  palette write strobe.
- i_Palette_Index  input  BITS_PER_PIXEL  palette entry to write.
- i_Palette_Data  input  12  {R[3:0],G[3:0],B[3:0]}.
- o_Red, o_Green, o_Blue  output  4 each  colour outputs.
- o_HSync, o_VSync  output  1 each  sync outputs, active-low.
- o_Frame_Start  output  1  one-clock pulse at the start of each frame.

Behaviour:
- Reset, asynchronous and active-high: divider, H and V counters, address counter = 0.
  - o_Read_Addr = 0; o_Red/o_Green/o_Blue = 0; o_HSync = o_VSync = 1; o_Frame_Start = 0.
  - Palette entry n = {n,n,n} (grayscale).
  - Pipeline valid/active flags cleared.
- Divider: counts 0..CLOCKS_PER_PIXEL-1. Tick is asserted the clock the count equals CLOCKS_PER_PIXEL-1; the count then wraps to 0. After reset release, the first tick is on clock CLOCKS_PER_PIXEL.
- Counters advance only on tick:
  - H runs 0..799 and wraps to 0.
  - V increments when H wraps and runs 0..524, wrapping to 0.
- Decode of the current (H,V), pre-increment:
  - active = H<640 && V<480.
  - hsync_n = !(656<=H<752).
  - vsync_n = !(490<=V<492).
- Stage 1, at tick:
  - If active: o_Read_Addr <= address counter, then the counter increments. Otherwise o_Read_Addr holds its value.
  - The address counter clears to 0 when (H,V) = (0,0), before use, so the address equals V*640+H for visible pixels with no multiplier.
  - active, hsync_n and vsync_n are registered into stage-1 flags.
  - o_Frame_Start = 1 for exactly this clock when (H,V) = (0,0); 0 otherwise.
- Stage 2, at the next tick:
  - i_Read_Data is sampled; it is valid because CLOCKS_PER_PIXEL >= 2.
  - RGB <= stage-1 active ? palette[i_Read_Data] : 0.
  - o_HSync and o_VSync <= the stage-1 flags.
- Total latency: 2 ticks from counter position to pins. Sync, blank and colour stay mutually aligned.
- Blanking: RGB is forced to 0 regardless of i_Read_Data. Out-of-range framebuffer reads return 0 and need no special handling here.
- Palette write: takes effect on the clock the strobe is sampled, independent of tick.
  - A write coinciding with a stage-2 capture of the same entry yields the old value for that pixel.
  - The new value applies from the next capture on.
- Reset mid-frame: all state returns to the reset values immediately. Scan restarts at (0,0) with the first tick after release; no partial pixel is emitted.
- Frame period: 800*525*CLOCKS_PER_PIXEL clocks (1,680,000 at default).

Test Plan:
- Hold reset, then release → during reset, RGB=0 and HSync=VSync=1; first o_Frame_Start pulse 4 clocks after release; o_Read_Addr=0 on that same tick.
- Free-run one line → o_Read_Addr takes values 0,1,2…639 on consecutive ticks and holds 639 through blanking; on line 1 the sequence starts at 640.
- Measure sync timing → HSync low for exactly 96 ticks (384 clocks), first low 2 ticks after H=656; VSync low for exactly 2 lines (1600 ticks).
- Count frame pulses → consecutive o_Frame_Start pulses are exactly 1,680,000 clocks apart, and each is 1 clock wide.
- Drive i_Read_Data=4'hF throughout → visible RGB = F,F,F. Write palette[15]=12'hA53 → later visible pixels output R=A, G=5, B=3. During blanking, outputs are 0.
- Assert reset at H=300, V=200 for 3 clocks → outputs return to reset values asynchronously (within the same clock); after release, addresses restart at 0 and the palette is back to grayscale.
